// File: rtl/regfile_multiport_pkg.sv
// Shared widths, register typedefs and the one-hot address decoder used by the
// write port, the scoreboard and every read-port mux of regfile_multiport.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;
   localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

   localparam reg_addr_t ZERO_ADDR = '0;

   function automatic logic [DEF_DEPTH-1:0] onehot_dec(input reg_addr_t addr);
      logic [DEF_DEPTH-1:0] dec;
      dec       = '0;
      dec[addr] = 1'b1;
      return dec;
   endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode-stage bus of regfile_multiport: one write port, NUM_RD read ports and the
// scoreboard set port. Clock and reset stay outside the interface.
interface regfile_multiport_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);

   logic                     ctrl_writeEnable;
   logic [ADDR_W-1:0]        ctrl_writeReg;
   logic [DATA_W-1:0]        data_writeReg;
   logic [NUM_RD*ADDR_W-1:0] ctrl_readReg;
   logic [NUM_RD-1:0]        ctrl_readEn;
   logic [NUM_RD*DATA_W-1:0] data_readReg;
   logic [NUM_RD-1:0]        read_valid;
   logic                     sb_setEn;
   logic [ADDR_W-1:0]        sb_setReg;
   logic [NUM_RD-1:0]        read_busy;

   // There is no backpressure: a request sampled with ctrl_readEn[i]=1 at a rising
   // edge is always accepted, and read_valid[i] is a one-cycle pulse after that same
   // edge saying data_readReg slice i now holds the captured register.
   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_readReg, ctrl_readEn, sb_setEn, sb_setReg,
      input  data_readReg, read_valid, read_busy
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_readReg, ctrl_readEn, sb_setEn, sb_setReg,
      output data_readReg, read_valid, read_busy
   );

endinterface

// File: rtl/regfile_multiport_read_port.sv
// rf_read_port: one registered read port (AND-OR select, output register, valid flop).
// Same-edge write forwarding and busy masking exist only with WRITE_BYPASS_EN defined.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int  DATA_W   = DEF_DATA_W,
   parameter int  ADDR_W   = DEF_ADDR_W,
   parameter int  ZERO_REG = 1,
   localparam int DEPTH    = 2 ** ADDR_W
) (
   input  logic                          clock,
   input  logic                          rst_n,
   input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
   input  logic [DEPTH-1:0]              busy,
   input  logic [ADDR_W-1:0]             addr,
   input  logic                          rd_en,
`ifdef WRITE_BYPASS_EN
   input  logic                          we,
   input  logic [ADDR_W-1:0]             waddr,
   input  logic [DATA_W-1:0]             wdata,
   input  logic                          set_en,
   input  logic [ADDR_W-1:0]             set_reg,
`endif
   output logic [DATA_W-1:0]             data,
   output logic                          valid,
   output logic                          busy_out
);

   logic [DEPTH-1:0]  sel;
   logic [DATA_W-1:0] mux_data;
   logic [DATA_W-1:0] next_data;
   logic              zero_hit;

   always_comb begin
      sel      = onehot_dec(addr);
      mux_data = '0;
      for (int j = 0; j < DEPTH; j++) begin
         mux_data = mux_data | (regs[j] & {DATA_W{sel[j]}});
      end
      zero_hit  = (ZERO_REG != 0) && (addr == ZERO_ADDR);
      next_data = zero_hit ? '0 : mux_data;
      busy_out  = |(busy & sel);
`ifdef WRITE_BYPASS_EN
      if (we && (waddr == addr) && !zero_hit) begin
         next_data = wdata;
      end
      // The write retires the producer now, unless a new producer is issued alongside.
      if (we && (waddr == addr) && !(set_en && (set_reg == addr))) begin
         busy_out = 1'b0;
      end
`endif
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= rd_en;
         if (rd_en) begin
            data <= next_data;
         end
      end
   end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with pending-write scoreboard; holds the register array,
// write decode and busy bits. Optional same-edge bypass: `define WRITE_BYPASS_EN.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1
) (
   input logic              clock,
   input logic              ctrl_reset_n,
   regfile_multiport_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic [DEPTH-1:0]             busy;
   logic [DEPTH-1:0]             wr_sel;
   logic [DEPTH-1:0]             set_sel;
   logic [DEPTH-1:0]             keep_mask;

   wire  [NUM_RD-1:0][DATA_W-1:0] rd_data;
   wire  [NUM_RD-1:0]             rd_valid;
   wire  [NUM_RD-1:0]             rd_busy;

   // Masking bit 0 of both decodes keeps reg0 and busy[0] at zero forever.
   always_comb begin
      keep_mask = '1;
      if (ZERO_REG != 0) begin
         keep_mask[0] = 1'b0;
      end
      wr_sel  = bus.ctrl_writeEnable ? (onehot_dec(bus.ctrl_writeReg) & keep_mask) : '0;
      set_sel = bus.sb_setEn         ? (onehot_dec(bus.sb_setReg)     & keep_mask) : '0;
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         regs <= '0;
      end else begin
         for (int j = 0; j < DEPTH; j++) begin
            if (wr_sel[j]) begin
               regs[j] <= bus.data_writeReg;
            end
         end
      end
   end

   // Set is applied after clear so a same-edge reissue keeps the register busy.
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~wr_sel) | set_sel;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      rf_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .clock    (clock),
         .rst_n    (ctrl_reset_n),
         .regs     (regs),
         .busy     (busy),
         .addr     (bus.ctrl_readReg[g*ADDR_W +: ADDR_W]),
         .rd_en    (bus.ctrl_readEn[g]),
`ifdef WRITE_BYPASS_EN
         .we       (bus.ctrl_writeEnable),
         .waddr    (bus.ctrl_writeReg),
         .wdata    (bus.data_writeReg),
         .set_en   (bus.sb_setEn),
         .set_reg  (bus.sb_setReg),
`endif
         .data     (rd_data[g]),
         .valid    (rd_valid[g]),
         .busy_out (rd_busy[g])
      );
   end

   assign bus.data_readReg = rd_data;
   assign bus.read_valid   = rd_valid;
   assign bus.read_busy    = rd_busy;

endmodule
